// File: rtl/tl_event_pkg.sv
// tl_event_pkg
// Shared definitions for the TileLink event arbiter: channel encodings, the
// field layout of an event record, the output-register state type and a small
// index helper. Taps and the logger both import this so they agree on layout.
package tl_event_pkg;

    // TileLink channel encodings carried in the record's channel field.
    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;
    localparam int unsigned CH_C = 2;
    localparam int unsigned CH_D = 3;
    localparam int unsigned CH_E = 4;

    // Record layout inside a 128-bit event. The arbiter treats the record as
    // opaque; these offsets only exist so producers and the logger agree.
    localparam int unsigned EVT_ID_LSB       = 0;
    localparam int unsigned EVT_ID_WD        = 32;
    localparam int unsigned EVT_BUS_TYPE_LSB = 32;
    localparam int unsigned EVT_BUS_TYPE_WD  = 4;
    localparam int unsigned EVT_CHANNEL_LSB  = 36;
    localparam int unsigned EVT_CHANNEL_WD   = 3;
    localparam int unsigned EVT_OPCODE_LSB   = 39;
    localparam int unsigned EVT_OPCODE_WD    = 3;
    localparam int unsigned EVT_PARAM_LSB    = 42;
    localparam int unsigned EVT_PARAM_WD     = 3;
    localparam int unsigned EVT_SOURCE_LSB   = 45;
    localparam int unsigned EVT_SOURCE_WD    = 16;
    localparam int unsigned EVT_ADDRESS_LSB  = 64;
    localparam int unsigned EVT_ADDRESS_WD   = 64;

    // Output register occupancy.
    typedef enum logic {
        OutEmpty = 1'b0,
        OutFull  = 1'b1
    } out_state_e;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tl_event_fifo.sv
// tl_event_fifo
// Per-tap event buffer. Circular FIFO with a synchronous flush and support for
// push and pop in the same cycle even when full (the slot freed by the pop is
// reused by the push). The caller only asserts push when the write can land.
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   flush           synchronous clear of all entries
//   push, wdata     write request and data
//   pop             remove the head entry
//   rdata           head entry (valid while !empty)
//   full, empty     occupancy flags
module tl_event_fifo
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrWd = $clog2(DEPTH);
    localparam int unsigned CntWd = $clog2(DEPTH) + 1;

    logic [PtrWd-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWd-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWd-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full  = (count_q == CntWd'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so the pointers wrap on overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrWd'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrWd'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntWd'(1);
                2'b01:   count_d = count_q - CntWd'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/tl_event_arbiter.sv
// tl_event_arbiter
// Merges per-tap TileLink monitor events into one stream. Each tap feeds its
// own FIFO (taps cannot be stalled, so a full FIFO drops and counts the event);
// a round-robin arbiter loads a single output register towards the logger.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   in_valid/in_data per-tap event strobe and record (tap k at [k*EVT_WD +: EVT_WD])
//   out_valid/out_ready/out_data  output handshake and granted record
//   out_port         tap index of the current record
//   out_drop         events from that tap were lost before this record
//   flush            synchronous clear of FIFOs, output register and lost flags
//   clear_drops      synchronous zeroing of the drop counters
//   drop_cnt         per-tap saturating drop counters (tap k at [k*CNT_WD +: CNT_WD])
module tl_event_arbiter
    import tl_event_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned EVT_WD     = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WD     = 16,
    localparam int unsigned PORT_WD   = $clog2(NUM_PORTS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*EVT_WD-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EVT_WD-1:0]           out_data,
    output logic [PORT_WD-1:0]          out_port,
    output logic                        out_drop,
    input  logic                        flush,
    input  logic                        clear_drops,
    output logic [NUM_PORTS*CNT_WD-1:0] drop_cnt
);

    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_push;
    logic [NUM_PORTS-1:0] fifo_pop;
    logic [NUM_PORTS-1:0] drop;
    logic [EVT_WD-1:0]    fifo_head [NUM_PORTS];

    logic [PORT_WD-1:0] ptr_q, ptr_d;
    logic [PORT_WD-1:0] grant;
    logic               grant_vld;
    logic               load_en;
    int unsigned        idx;

    out_state_e           out_state_q, out_state_d;
    logic [EVT_WD-1:0]    out_data_q, out_data_d;
    logic [PORT_WD-1:0]   out_port_q, out_port_d;
    logic                 out_drop_q, out_drop_d;
    logic [NUM_PORTS-1:0] lost_q, lost_d;
    logic [CNT_WD-1:0]    cnt_q [NUM_PORTS];
    logic [CNT_WD-1:0]    cnt_d [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_tap
        tl_event_fifo #(
            .WIDTH (EVT_WD),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .flush   (flush),
            .push    (fifo_push[k]),
            .wdata   (in_data[k*EVT_WD +: EVT_WD]),
            .pop     (fifo_pop[k]),
            .rdata   (fifo_head[k]),
            .full    (fifo_full[k]),
            .empty   (fifo_empty[k])
        );

        assign drop_cnt[k*CNT_WD +: CNT_WD] = cnt_q[k];
    end

    // Round-robin: first non-empty FIFO at or after ptr_q.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!grant_vld && !fifo_empty[idx[PORT_WD-1:0]]) begin
                grant     = idx[PORT_WD-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    assign load_en = grant_vld && !flush && ((out_state_q == OutEmpty) || out_ready);

    // A full FIFO still accepts a push when its head is popped in the same cycle.
    always_comb begin
        fifo_pop  = '0;
        fifo_push = '0;
        drop      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            fifo_pop[k]  = load_en && (grant == PORT_WD'(k));
            fifo_push[k] = in_valid[k] && !flush && (!fifo_full[k] || fifo_pop[k]);
            drop[k]      = in_valid[k] && !flush && fifo_full[k] && !fifo_pop[k];
        end
    end

    // Drop counters: clear wins over increment, but a same-cycle drop still counts.
    always_comb begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clear_drops) begin
                cnt_d[k] = drop[k] ? CNT_WD'(1) : '0;
            end else if (drop[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNT_WD'(1);
            end
        end
    end

    // Lost flags: a load clears the granted flag, a same-cycle drop re-sets it.
    always_comb begin
        lost_d = lost_q;
        if (flush) begin
            lost_d = '0;
        end else begin
            if (load_en) begin
                lost_d[grant] = 1'b0;
            end
            lost_d = lost_d | drop;
        end
    end

    // Output register and arbitration pointer.
    always_comb begin
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        out_drop_d  = out_drop_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_state_d = OutEmpty;
        end else if (load_en) begin
            out_state_d = OutFull;
            out_data_d  = fifo_head[grant];
            out_port_d  = grant;
            out_drop_d  = lost_q[grant];
            ptr_d       = PORT_WD'(wrap_inc(32'(grant), NUM_PORTS));
        end else begin
            case (out_state_q)
                OutFull: begin
                    if (out_ready) begin
                        out_state_d = OutEmpty;
                    end
                end
                default: out_state_d = out_state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_state_q <= OutEmpty;
            out_data_q  <= '0;
            out_port_q  <= '0;
            out_drop_q  <= 1'b0;
            ptr_q       <= '0;
            lost_q      <= '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            out_drop_q  <= out_drop_d;
            ptr_q       <= ptr_d;
            lost_q      <= lost_d;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out_valid = (out_state_q == OutFull);
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign out_drop  = out_drop_q;

endmodule

// File: tb/tb_tl_event_arbiter.sv
// Bench for tl_event_arbiter: directed scenarios plus randomized traffic, with
// a queue-based reference model feeding a scoreboard that an independent
// monitor drains on every output handshake.
module tb_tl_event_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned EW = 32;
    localparam int unsigned FD = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned PW = 2;
    localparam int CNT_MAX = 3;

    logic             clock;
    logic             reset_n;
    logic [NP-1:0]    in_valid;
    logic [NP*EW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [EW-1:0]    out_data;
    logic [PW-1:0]    out_port;
    logic             out_drop;
    logic             flush;
    logic             clear_drops;
    logic [NP*CW-1:0] drop_cnt;

    tl_event_arbiter #(
        .NUM_PORTS  (NP),
        .EVT_WD     (EW),
        .FIFO_DEPTH (FD),
        .CNT_WD     (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_port    (out_port),
        .out_drop    (out_drop),
        .flush       (flush),
        .clear_drops (clear_drops),
        .drop_cnt    (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [EW-1:0] data;
        logic [PW-1:0] port;
        logic          drop;
    } rec_t;

    int checks;
    int failures;

    // Scoreboard and reference model state.
    rec_t          exp_q[$];
    int unsigned   seen_port[$];
    logic [EW-1:0] mq [NP][$];
    bit            m_full;
    bit [NP-1:0]   m_lost;
    int            m_cnt [NP];
    int            m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            mq[k].delete();
            m_cnt[k] = 0;
        end
        m_full = 0;
        m_lost = '0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    // One clock cycle of the specified behaviour: arbitrate on the contents
    // present at the start of the cycle, then accept or drop new events.
    task automatic model_step(input logic [NP-1:0] iv, input logic [NP*EW-1:0] id,
                              input logic rdy, input logic fl, input logic cl);
        int   g;
        int   k;
        bit   dr;
        rec_t r;
        g = -1;
        if (fl) begin
            for (int j = 0; j < NP; j++) begin
                mq[j].delete();
                if (cl) m_cnt[j] = 0;
            end
            m_lost = '0;
            // An unaccepted record in the output register is discarded.
            if (m_full && !rdy && exp_q.size() > 0) void'(exp_q.pop_back());
            m_full = 0;
        end else begin
            if (!m_full || rdy) begin
                for (int i = 0; i < NP; i++) begin
                    k = (m_ptr + i) % NP;
                    if (g < 0 && mq[k].size() > 0) g = k;
                end
            end
            if (g >= 0) begin
                r.data = mq[g].pop_front();
                r.port = PW'(g);
                r.drop = m_lost[g];
                exp_q.push_back(r);
                m_lost[g] = 0;
                m_ptr     = (g + 1) % NP;
                m_full    = 1;
            end else if (m_full && rdy) begin
                m_full = 0;
            end
            for (int j = 0; j < NP; j++) begin
                dr = iv[j] && (mq[j].size() >= FD);
                if (iv[j] && !dr) mq[j].push_back(id[j*EW +: EW]);
                if (cl) m_cnt[j] = dr ? 1 : 0;
                else if (dr && m_cnt[j] < CNT_MAX) m_cnt[j]++;
                if (dr) m_lost[j] = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check the counters.
    task automatic step(input logic [NP-1:0] iv, input logic [NP*EW-1:0] id,
                        input logic rdy, input logic fl, input logic cl);
        in_valid    = iv;
        in_data     = id;
        out_ready   = rdy;
        flush       = fl;
        clear_drops = cl;
        model_step(iv, id, rdy, fl, cl);
        @(posedge clock);
        #1;
        for (int k = 0; k < NP; k++) begin
            check($sformatf("drop_cnt[%0d]", k), 64'(drop_cnt[k*CW +: CW]), 64'(m_cnt[k]));
        end
    endtask

    function automatic logic [NP*EW-1:0] rand_data();
        logic [NP*EW-1:0] d;
        for (int k = 0; k < NP; k++) d[k*EW +: EW] = $urandom();
        return d;
    endfunction

    // Monitor: compares every accepted record and checks payload stability.
    initial begin
        rec_t got;
        rec_t e;
        rec_t held;
        bit   hold;
        hold = 0;
        held = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                hold = 0;
            end else begin
                got = {out_data, out_port, out_drop};
                if (hold) begin
                    check("hold_valid", 64'(out_valid), 64'(1));
                    check("hold_payload", 64'(got), 64'(held));
                end
                if (out_valid && out_ready) begin
                    seen_port.push_back(32'(out_port));
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_record: actual port=%0d data=%0h required=none",
                                 out_port, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("record", 64'(got), 64'(e));
                    end
                end
                hold = out_valid && !out_ready && !flush;
                held = got;
            end
        end
    end

    initial begin
        logic [NP*EW-1:0] d;
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        clear_drops = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_port", 64'(out_port), 64'(0));
        check("rst_out_drop", 64'(out_drop), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Fairness: every tap pushes every cycle, logger always ready.
        repeat (12) step('1, rand_data(), 1'b1, 1'b0, 1'b0);
        repeat (20) step('0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("fair_port", (seen_port.size() > i) ? 64'(seen_port[i]) : 64'(99), 64'(i % 4));
        end
        seen_port.delete();

        // Single event latency on tap 2.
        d = '0;
        d[2*EW +: EW] = 32'hA5;
        step(4'b0100, d, 1'b1, 1'b0, 1'b0);
        check("lat_t1_valid", 64'(out_valid), 64'(0));
        step('0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_t2_valid", 64'(out_valid), 64'(1));
        check("lat_t2_data", 64'(out_data), 64'(32'hA5));
        check("lat_t2_port", 64'(out_port), 64'(2));
        check("lat_t2_drop", 64'(out_drop), 64'(0));
        step('0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_t3_valid", 64'(out_valid), 64'(0));

        // Overflow on tap 0 with the logger stalled.
        step('0, '0, 1'b1, 1'b0, 1'b1);
        repeat (6) step(4'b0001, rand_data(), 1'b0, 1'b0, 1'b0);
        check("ovf_drop_cnt0", 64'(drop_cnt[0 +: CW]), 64'(1));
        repeat (8) step('0, '0, 1'b1, 1'b0, 1'b0);

        // Saturation and clear on tap 1.
        step('0, '0, 1'b0, 1'b1, 1'b1);
        repeat (10) step(4'b0010, rand_data(), 1'b0, 1'b0, 1'b0);
        check("sat_drop_cnt1", 64'(drop_cnt[CW +: CW]), 64'(3));
        step(4'b0010, rand_data(), 1'b0, 1'b0, 1'b1);
        check("clr_drop_cnt1", 64'(drop_cnt[CW +: CW]), 64'(1));

        // Push into full FIFO 3 while it is popped.
        step('0, '0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(4'b1000, rand_data(), 1'b0, 1'b0, 1'b0);
        check("fp_pre_cnt3", 64'(drop_cnt[3*CW +: CW]), 64'(0));
        step(4'b1000, rand_data(), 1'b1, 1'b0, 1'b0);
        check("fp_nodrop_cnt3", 64'(drop_cnt[3*CW +: CW]), 64'(0));
        step(4'b1000, rand_data(), 1'b0, 1'b0, 1'b0);
        check("fp_occupancy_cnt3", 64'(drop_cnt[3*CW +: CW]), 64'(1));

        // Flush with records buffered and the output register full.
        check("pre_flush_valid", 64'(out_valid), 64'(1));
        step('0, '0, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_cnt3", 64'(drop_cnt[3*CW +: CW]), 64'(1));
        step('0, '0, 1'b1, 1'b0, 1'b0);
        check("post_flush_valid", 64'(out_valid), 64'(0));

        // Randomized traffic.
        repeat (400) begin
            step(NP'($urandom()), rand_data(), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset in the middle of a stalled stream.
        repeat (6) step('1, rand_data(), 1'b0, 1'b0, 1'b0);
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_data", 64'(out_data), 64'(0));
        check("mid_rst_out_port", 64'(out_port), 64'(0));
        check("mid_rst_out_drop", 64'(out_drop), 64'(0));
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
        in_valid    = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        clear_drops = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        repeat (150) begin
            step(NP'($urandom()), rand_data(), 1'($urandom_range(0, 9) < 6), 1'b0,
                 1'($urandom_range(0, 39) == 0));
        end
        repeat (30) step('0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("drain_out_valid", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
